// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller feeding one shared BCD-to-7-segment decoder.
// Optional build macro LEAD_ZERO_BLANK_EN enables leading-zero blanking of digit 3.
module seg7_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYCLES  = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  blink_mask,
   input  logic        colon_on,
   input  logic        blank_lead,
   output logic [3:0]  bcd_out,
   output logic [3:0]  an,
   output logic        dp_n,
   output logic        frame_tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD      = CW'(DEAD_CYCLES);
   localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic [BW-1:0] bcnt;
   logic          phase;

   logic [3:0] nib, an_nxt, bcd_nxt;
   logic       bad, lead, blanked, dead, dp_nxt, slot_end, frame_end;

   always_comb begin
      nib       = shadow[{idx, 2'b00} +: 4];
      bad       = nib > 4'd9;
`ifdef LEAD_ZERO_BLANK_EN
      lead      = blank_lead && (idx == 2'd3) && (nib == 4'h0);
`else
      lead      = blank_lead & 1'b0;
`endif
      blanked   = bad | (blink_mask[idx] & phase) | lead;
      dead      = cnt < DEAD;
      slot_end  = cnt == CNT_LAST;
      frame_end = slot_end && (idx == 2'd3);
      an_nxt    = (dead || blanked) ? 4'b1111 : ~(4'b0001 << idx);
      // Unmapped codes never reach the decoder, even while the anode is off.
      bcd_nxt   = bad ? 4'h0 : nib;
      dp_nxt    = !(colon_on && (idx == 2'd2) && !dead && !blanked);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         shadow     <= 16'h0000;
         bcnt       <= '0;
         phase      <= 1'b0;
         an         <= 4'b1111;
         bcd_out    <= 4'h0;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= idx + 2'd1;
         // Digits are captured only at frame end so a frame never mixes two times.
         if (frame_end) begin
            shadow <= digits;
            if (bcnt == BCNT_LAST) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         an         <= an_nxt;
         bcd_out    <= bcd_nxt;
         dp_n       <= dp_nxt;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic [3:0]  blink_mask;
   logic        colon_on;
   logic        blank_lead;
   logic [3:0]  bcd_out;
   logic [3:0]  an;
   logic        dp_n;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   seg7_scan_ctrl #(.SCAN_DIV(8), .DEAD_CYCLES(2), .BLINK_FRAMES(2)) dut (
      .clk(clk), .reset(reset), .digits(digits), .blink_mask(blink_mask),
      .colon_on(colon_on), .blank_lead(blank_lead), .bcd_out(bcd_out),
      .an(an), .dp_n(dp_n), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " an"}, an, 4'b1111);
      chk({tag, " bcd"}, bcd_out, 4'h0);
      chk({tag, " dp"}, {3'b000, dp_n}, 4'h1);
      chk({tag, " ft"}, {3'b000, frame_tick}, 4'h0);
   endtask

   // Eight output samples of one slot; an_l/dp_l are the values after dead-time.
   task automatic check_slot(input int s, input logic [3:0] an_l, input logic [3:0] bcd,
                             input logic dp_l);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("s%0d c%0d an", s, c), an, (c < 2) ? 4'b1111 : an_l);
         chk($sformatf("s%0d c%0d bcd", s, c), bcd_out, bcd);
         chk($sformatf("s%0d c%0d dp", s, c), {3'b000, dp_n}, {3'b000, (c < 2) ? 1'b1 : dp_l});
         chk($sformatf("s%0d c%0d ft", s, c), {3'b000, frame_tick},
             {3'b000, (s == 3 && c == 7)});
      end
   endtask

   task automatic check_frame(input logic [15:0] anv, input logic [15:0] bcdv, input logic [3:0] dpv);
      for (int s = 0; s < 4; s++)
         check_slot(s, anv[4*s +: 4], bcdv[4*s +: 4], dpv[s]);
   endtask

   initial begin
      reset = 1'b1; digits = 16'h1234; blink_mask = 4'b0000; colon_on = 1'b1; blank_lead = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_idle("reset");
      end
      reset = 1'b0;

      // Frame 0 shows the cleared shadow; frame_tick lands on the 32nd cycle.
      check_frame(16'h7BDE, 16'h0000, 4'b1011);
      check_frame(16'h7BDE, 16'h1234, 4'b1011);

      // Blink digits 0/1: dark in frames 2,3 and 6, lit in frames 4,5.
      blink_mask = 4'b0011;
      check_frame(16'h7BFF, 16'h1234, 4'b1011);
      check_frame(16'h7BFF, 16'h1234, 4'b1011);
      check_frame(16'h7BDE, 16'h1234, 4'b1011);
      check_frame(16'h7BDE, 16'h1234, 4'b1011);
      digits = 16'h12A4;
      check_frame(16'h7BFF, 16'h1234, 4'b1011);

      // Invalid nibble in digit 1 is blanked with bcd forced to 0.
      blink_mask = 4'b0000;
      digits = 16'h1234;
      check_frame(16'h7BFE, 16'h1204, 4'b1011);

      // Mid-frame digit change stays invisible until the next frame end.
      check_slot(0, 4'b1110, 4'h4, 1'b1);
      digits = 16'h5678;
      check_slot(1, 4'b1101, 4'h3, 1'b1);
      check_slot(2, 4'b1011, 4'h2, 1'b0);
      check_slot(3, 4'b0111, 4'h1, 1'b1);
      check_frame(16'h7BDE, 16'h5678, 4'b1011);

      // Reset in slot 2 forces outputs immediately; scan restarts at slot 0.
      check_slot(0, 4'b1110, 4'h8, 1'b1);
      check_slot(1, 4'b1101, 4'h7, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("pre-reset s2 c%0d an", c), an, (c < 2) ? 4'b1111 : 4'b1011);
      end
      reset = 1'b1;
      digits = 16'h0930;
      blank_lead = 1'b1;
      #1;
      chk_idle("async reset");
      @(negedge clk);
      chk_idle("held reset");
      reset = 1'b0;

`ifdef LEAD_ZERO_BLANK_EN
      check_frame(16'hFBDE, 16'h0000, 4'b1011);
      colon_on = 1'b0;
      check_frame(16'hFBDE, 16'h0930, 4'b1111);
`else
      check_frame(16'h7BDE, 16'h0000, 4'b1011);
      colon_on = 1'b0;
      check_frame(16'h7BDE, 16'h0930, 4'b1111);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
